// File: rtl/segment_pkg.sv
// Purpose: shared types and constants for the write-side memory segment.
// Latency: n/a (types, constants and a constant function only).
// Backpressure: n/a.
package segment_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        DONE = 1'b1
    } seg_state_t;

    localparam int ADDR_TOK_W = 32;
    localparam int DW_DEF     = 64;
    localparam int DEPTH_DEF  = 1024;

    // Ceiling log2, usable in parameter defaults.
    function automatic int seg_clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// Purpose: one-entry token holding register (payload, eos flag, full flag).
// Latency: a token accepted at an edge is visible as full the following cycle.
// Backpressure: none internally; load wins over clear so the slot refills while firing.
import segment_pkg::*;

module stream_hold_reg #(
    parameter int W = DW_DEF
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] in_d,
    input  logic         in_e,
    output logic         full,
    output logic [W-1:0] dat,
    output logic         eos
);

    // Capture on accept; otherwise drop the entry when the pair logic consumes it.
    always_ff @(posedge clock) begin
        if (reset) begin
            full <= 1'b0;
            dat  <= '0;
            eos  <= 1'b0;
        end else if (load) begin
            full <= 1'b1;
            dat  <= in_d;
            eos  <= in_e;
        end else if (clr) begin
            full <= 1'b0;
            eos  <= 1'b0;
        end
    end

endmodule

// File: rtl/segment_w_0.sv
// Purpose: pairs address/data tokens and writes them into a DEPTH x DW memory; optional SEGMENT_W_BOUNDS_CHK_EN.
// Latency: write lands at the edge after both tokens are held; debug read is 1 cycle.
// Backpressure: x_b from held-register state only (one side full and waiting, or DONE).
import segment_pkg::*;

module segment_w_0 #(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = seg_clog2(DEPTH),
    parameter int DW    = DW_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_TOK_W-1:0] addr_d,
    input  logic                  addr_e,
    input  logic                  addr_v,
    output logic                  addr_b,
    input  logic [DW-1:0]         data_d,
    input  logic                  data_e,
    input  logic                  data_v,
    output logic                  data_b,
    input  logic [AW-1:0]         rd_addr,
    output logic [DW-1:0]         rd_data,
    output logic [31:0]           wr_count,
    output logic                  done,
    output logic                  err
);

    seg_state_t state_q, state_d;

    logic                  a_full, a_eos, d_full, d_eos;
    logic [ADDR_TOK_W-1:0] a_dat;
    logic [DW-1:0]         d_dat;
    logic                  a_load, d_load, a_clr, d_clr;
    logic                  fire, pair_data, pair_eos, pair_mixed;
    logic                  oob, wr_en;
    logic [DW-1:0]         mem [DEPTH];
    logic                  unused_addr_hi;

    assign addr_b = (a_full & ~d_full) | (state_q == DONE);
    assign data_b = (d_full & ~a_full) | (state_q == DONE);
    assign a_load = addr_v & ~addr_b;
    assign d_load = data_v & ~data_b;

    assign fire       = a_full & d_full & (state_q == RUN);
    assign pair_data  = fire & ~a_eos & ~d_eos;
    assign pair_eos   = fire & a_eos & d_eos;
    assign pair_mixed = fire & (a_eos ^ d_eos);

`ifdef SEGMENT_W_BOUNDS_CHK_EN
    assign oob = (a_dat >= ADDR_TOK_W'(DEPTH));
`else
    assign oob = 1'b0;
`endif
    assign wr_en = pair_data & ~oob;

    // On an eos/non-eos mismatch only the eos side stays held, waiting for its partner.
    assign a_clr = fire & ~(a_eos & ~d_eos);
    assign d_clr = fire & ~(d_eos & ~a_eos);

    // Upper token bits never index the array when the range check is absent.
    assign unused_addr_hi = ^a_dat[ADDR_TOK_W-1:AW];

    stream_hold_reg #(.W(ADDR_TOK_W)) u_addr_hold (
        .clock (clock),
        .reset (reset),
        .load  (a_load),
        .clr   (a_clr),
        .in_d  (addr_d),
        .in_e  (addr_e),
        .full  (a_full),
        .dat   (a_dat),
        .eos   (a_eos)
    );

    stream_hold_reg #(.W(DW)) u_data_hold (
        .clock (clock),
        .reset (reset),
        .load  (d_load),
        .clr   (d_clr),
        .in_d  (data_d),
        .in_e  (data_e),
        .full  (d_full),
        .dat   (d_dat),
        .eos   (d_eos)
    );

    // State register; DONE is left only through reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: an eos pair terminates the segment.
    always_comb begin
        state_d = state_q;
        done    = (state_q == DONE);
        if (state_q == RUN && pair_eos) begin
            state_d = DONE;
        end
    end

    // Commit counter and sticky error flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_count <= '0;
            err      <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_count <= wr_count + 32'd1;
            end
            if (pair_mixed | (pair_data & oob)) begin
                err <= 1'b1;
            end
        end
    end

    // Memory write port; contents survive reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[a_dat[AW-1:0]] <= d_dat;
        end
    end

    // Registered debug read; a same-edge write to the same index returns the old word.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_segment_w_0.sv
// Purpose: directed, table-driven self-checking bench for segment_w_0.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: stream driver honours addr_b/data_b and counts stalled cycles.
module tb_segment_w_0;

    localparam int DEPTH = 1024;
    localparam int AW    = 10;
    localparam int DW    = 64;
`ifdef SEGMENT_W_BOUNDS_CHK_EN
    localparam bit BCHK = 1'b1;
`else
    localparam bit BCHK = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic [31:0]   addr_d;
    logic          addr_e, addr_v, addr_b;
    logic [DW-1:0] data_d;
    logic          data_e, data_v, data_b;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [31:0]   wr_count;
    logic          done, err;

    always #5 clock = ~clock;

    segment_w_0 #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clock    (clock),
        .reset    (reset),
        .addr_d   (addr_d),
        .addr_e   (addr_e),
        .addr_v   (addr_v),
        .addr_b   (addr_b),
        .data_d   (data_d),
        .data_e   (data_e),
        .data_v   (data_v),
        .data_b   (data_b),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_count (wr_count),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        logic [31:0]   addr;
        logic [63:0]   data;
        logic [AW-1:0] idx;
        logic [63:0]   exp;
        bit            wr;
    } vec_t;

    vec_t vecs[6];

    int n_pass  = 0;
    int n_total = 0;
    int a_stall, d_stall, run_cycles;
    int exp_wr;

    logic [31:0] aq_d[$];
    bit          aq_e[$];
    logic [63:0] dq_d[$];
    bit          dq_e[$];

    function automatic logic [63:0] tp_data(input int i);
        return {32'hA5A50000 | 32'(i), 32'(i * 7 + 1)};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    endtask

    // Feed both queues into the DUT, each stream starting after its own delay.
    task automatic run_streams(input int a_dly, input int d_dly);
        int ai, di;
        bit a_acc, d_acc;
        ai = 0; di = 0;
        a_stall = 0; d_stall = 0; run_cycles = 0;
        while ((ai < aq_d.size() || di < dq_d.size()) && run_cycles < 3000) begin
            addr_v = (run_cycles >= a_dly) && (ai < aq_d.size());
            addr_d = addr_v ? aq_d[ai] : 32'd0;
            addr_e = addr_v ? aq_e[ai] : 1'b0;
            data_v = (run_cycles >= d_dly) && (di < dq_d.size());
            data_d = data_v ? dq_d[di] : 64'd0;
            data_e = data_v ? dq_e[di] : 1'b0;
            a_acc = addr_v && !addr_b;
            d_acc = data_v && !data_b;
            if (addr_v && addr_b) a_stall++;
            if (data_v && data_b) d_stall++;
            @(negedge clock);
            run_cycles++;
            if (a_acc) ai++;
            if (d_acc) di++;
        end
        addr_v = 1'b0;
        data_v = 1'b0;
        check("run_complete", 64'(ai + di), 64'(aq_d.size() + dq_d.size()));
        aq_d.delete(); aq_e.delete(); dq_d.delete(); dq_e.delete();
    endtask

    task automatic push_pair(input logic [31:0] a, input logic [63:0] d, input bit e);
        aq_d.push_back(a); aq_e.push_back(e);
        dq_d.push_back(d); dq_e.push_back(e);
    endtask

    task automatic read_mem(input logic [AW-1:0] idx, input logic [63:0] exp, input string name);
        rd_addr = idx;
        @(negedge clock);
        check(name, rd_data, exp);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'd20,         64'h0000_0000_0000_1111, 10'd20,   64'h0000_0000_0000_1111, 1'b1};
        vecs[1] = '{32'd21,         64'hCAFE_F00D_1234_5678, 10'd21,   64'hCAFE_F00D_1234_5678, 1'b1};
        vecs[2] = '{32'hABCD_0016,  64'h0BAD_0BAD_0000_0022, 10'd22,
                    BCHK ? tp_data(22) : 64'h0BAD_0BAD_0000_0022, !BCHK};
        vecs[3] = '{32'(DEPTH + 3), 64'h7777_0000_0000_0003, 10'd3,
                    BCHK ? tp_data(3) : 64'h7777_0000_0000_0003, !BCHK};
        vecs[4] = '{32'd1023,       64'hFFFF_FFFF_FFFF_FFFE, 10'd1023, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
        vecs[5] = '{32'd0,          64'h0123_4567_89AB_CDEF, 10'd0,    64'h0123_4567_89AB_CDEF, 1'b1};

        reset = 1'b1;
        addr_d = '0; addr_e = 1'b0; addr_v = 1'b0;
        data_d = '0; data_e = 1'b0; data_v = 1'b0;
        rd_addr = '0;
        repeat (2) @(negedge clock);
        check("rst_addr_b",   64'(addr_b),   64'd0);
        check("rst_data_b",   64'(data_b),   64'd0);
        check("rst_wr_count", 64'(wr_count), 64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_err",      64'(err),      64'd0);
        check("rst_rd_data",  rd_data,       64'd0);
        reset = 1'b0;
        @(negedge clock);

        // Full throughput: 256 back-to-back pairs.
        for (int i = 0; i < 256; i++) push_pair(32'(i), tp_data(i), 1'b0);
        run_streams(0, 0);
        check("tp_cycles",  64'(run_cycles), 64'd256);
        check("tp_a_stall", 64'(a_stall),    64'd0);
        check("tp_d_stall", 64'(d_stall),    64'd0);
        repeat (2) @(negedge clock);
        check("tp_wr_count", 64'(wr_count), 64'd256);
        read_mem(10'd1,   tp_data(1),   "tp_mem1");
        read_mem(10'd100, tp_data(100), "tp_mem100");
        read_mem(10'd255, tp_data(255), "tp_mem255");

        // Skewed: four addresses, data arriving 10 cycles later.
        for (int i = 0; i < 4; i++) begin
            aq_d.push_back(32'(300 + i)); aq_e.push_back(1'b0);
            dq_d.push_back(64'h5EED_0000_0000_0000 | 64'(i)); dq_e.push_back(1'b0);
        end
        run_streams(0, 10);
        check("skew_a_stall", 64'(a_stall),    64'd10);
        check("skew_cycles",  64'(run_cycles), 64'd14);
        repeat (2) @(negedge clock);
        check("skew_wr_count", 64'(wr_count), 64'd260);
        for (int i = 0; i < 4; i++)
            read_mem(AW'(300 + i), 64'h5EED_0000_0000_0000 | 64'(i), "skew_mem");

        // Table: one pair at a time, then read back the target index.
        exp_wr = 260;
        for (int k = 0; k < 6; k++) begin
            push_pair(vecs[k].addr, vecs[k].data, 1'b0);
            run_streams(0, 0);
            if (vecs[k].wr) exp_wr++;
            repeat (2) @(negedge clock);
            read_mem(vecs[k].idx, vecs[k].exp, "vec_mem");
        end
        check("vec_wr_count", 64'(wr_count), 64'(exp_wr));
        check("vec_err",      64'(err),      64'(BCHK));

        // Basic write followed by the eos pair.
        pulse_reset();
        push_pair(32'd5, 64'hDEADBEEF_00000001, 1'b0);
        push_pair(32'd0, 64'd0, 1'b1);
        run_streams(0, 0);
        repeat (2) @(negedge clock);
        check("basic_wr_count", 64'(wr_count), 64'd1);
        check("basic_done",     64'(done),     64'd1);
        check("basic_err",      64'(err),      64'd0);
        check("basic_b_done",   64'({addr_b, data_b}), 64'd3);
        read_mem(10'd5, 64'hDEADBEEF_00000001, "basic_mem5");

        // Mismatch: address eos meets pending data 0x55, then data eos terminates.
        pulse_reset();
        aq_d.push_back(32'd7); aq_e.push_back(1'b1);
        dq_d.push_back(64'h55); dq_e.push_back(1'b0);
        dq_d.push_back(64'h0);  dq_e.push_back(1'b1);
        run_streams(2, 0);
        repeat (2) @(negedge clock);
        check("mis_err",      64'(err),      64'd1);
        check("mis_wr_count", 64'(wr_count), 64'd0);
        check("mis_done",     64'(done),     64'd1);
        read_mem(10'd7, tp_data(7), "mis_mem7");

        // Reset with one address held: token must be discarded.
        pulse_reset();
        aq_d.push_back(32'd9); aq_e.push_back(1'b0);
        run_streams(0, 0);
        check("mid_held_b", 64'(addr_b), 64'd1);
        pulse_reset();
        check("mid_addr_b",   64'(addr_b),   64'd0);
        check("mid_data_b",   64'(data_b),   64'd0);
        check("mid_wr_count", 64'(wr_count), 64'd0);
        check("mid_done",     64'(done),     64'd0);
        push_pair(32'd12, 64'h1200_0000_0000_00AB, 1'b0);
        run_streams(0, 0);
        repeat (2) @(negedge clock);
        check("mid_wr_count2", 64'(wr_count), 64'd1);
        read_mem(10'd12, 64'h1200_0000_0000_00AB, "mid_mem12");
        read_mem(10'd9,  tp_data(9),              "mid_mem9");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
